// File: rtl/debouncer_pkg.sv
// Shared definitions for the multi-channel push-button debouncer.
//
// Contents:
//   deb_state_t        per-channel debounce state
//   DEB_SYNC_STAGES    default synchroniser depth
//   DEB_STABLE_CYCLES  default acceptance time in clock cycles
//   DEB_LONG_CYCLES    default long-press hold time in clock cycles
package debouncer_pkg;

    // S_LO / S_HI are the settled levels; the WAIT states mean that the
    // synchronised input currently disagrees with the settled level.
    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HI      = 2'd2,
        S_WAIT_LO = 2'd3
    } deb_state_t;

    localparam int unsigned DEB_SYNC_STAGES   = 2;
    localparam int unsigned DEB_STABLE_CYCLES = 50000;
    localparam int unsigned DEB_LONG_CYCLES   = 1000000;

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: input synchroniser, four-state stability FSM with
// its counter, registered level and edge-pulse outputs, and an optional
// long-press detector.
//
// Optional feature macro: DEBOUNCER_LONGPRESS_EN
//   defined   -> btn_long pulses once per press after LONG_CYCLES of hold
//   undefined -> btn_long is tied to 0 and no hold counter exists
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-low
//   btn       in   raw asynchronous button input
//   btn_stbl  out  debounced level
//   btn_rise  out  one-cycle pulse when btn_stbl goes 0->1
//   btn_fall  out  one-cycle pulse when btn_stbl goes 1->0
//   btn_long  out  one-cycle long-press pulse
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEB_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1),
    parameter int unsigned LONG_CYCLES   = DEB_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_stbl,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_long
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Stability FSM
    // ------------------------------------------------------------------
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stbl_q, stbl_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_LO;
            cnt_q   <= '0;
            stbl_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stbl_q  <= stbl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The first disagreeing sample already counts as one, so acceptance
    // happens on the STABLE_CYCLES-th consecutive disagreeing sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stbl_d  = stbl_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        unique case (state_q)
            S_LO: begin
                cnt_d = '0;
                if (s) begin
                    state_d = S_WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end

            S_WAIT_HI: begin
                if (!s) begin
                    state_d = S_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HI;
                    stbl_d  = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_HI: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = S_WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end

            S_WAIT_LO: begin
                if (s) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LO;
                    stbl_d  = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_LO;
                cnt_d   = '0;
                stbl_d  = 1'b0;
            end
        endcase
    end

    assign btn_stbl = stbl_q;
    assign btn_rise = rise_q;
    assign btn_fall = fall_q;

    // ------------------------------------------------------------------
    // Long-press detector
    // ------------------------------------------------------------------
`ifdef DEBOUNCER_LONGPRESS_EN
    localparam int unsigned     HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    // Parked one past the last count once the pulse has fired, so the
    // pulse cannot repeat until btn_stbl drops and clears the counter.
    localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    // Counting starts the cycle after S_HI is entered and pauses while a
    // release is being qualified in S_WAIT_LO.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!stbl_q) begin
            hold_d = '0;
        end else if (state_q == S_HI) begin
            if (hold_q == HOLD_LAST) begin
                long_d = 1'b1;
                hold_d = HOLD_DONE;
            end else if (hold_q != HOLD_DONE) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/module_debouncer_multi.sv
// N-channel push-button debouncer. Each channel is an independent
// debounce_channel instance; all channels share the one clock and reset.
//
// Optional feature macro: DEBOUNCER_LONGPRESS_EN (enables btn_long)
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-low
//   btn       in   [N_CH] raw asynchronous button inputs
//   btn_stbl  out  [N_CH] debounced level per channel
//   btn_rise  out  [N_CH] one-cycle pulse on 0->1 of btn_stbl
//   btn_fall  out  [N_CH] one-cycle pulse on 1->0 of btn_stbl
//   btn_long  out  [N_CH] one-cycle long-press pulse (0 without the macro)
module module_debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned SYNC_STAGES   = DEB_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1),
    parameter int unsigned LONG_CYCLES   = DEB_LONG_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] btn_stbl,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_long
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .btn      (btn[i]),
            .btn_stbl (btn_stbl[i]),
            .btn_rise (btn_rise[i]),
            .btn_fall (btn_fall[i]),
            .btn_long (btn_long[i])
        );
    end

endmodule

// File: tb/tb_module_debouncer_multi.sv
// Self-checking bench for module_debouncer_multi (N_CH=2, SYNC_STAGES=2,
// STABLE_CYCLES=4, LONG_CYCLES=10, 20 ns clock). A run-length reference
// model predicts every output each cycle; directed steps add explicit
// latency and pulse-count checks, followed by a randomised phase.
// Build with DEBOUNCER_LONGPRESS_EN defined to exercise btn_long.
module tb_module_debouncer_multi;

    localparam int N_CH   = 2;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int LONG   = 10;
`ifdef DEBOUNCER_LONGPRESS_EN
    localparam int LP_EN = 1;
`else
    localparam int LP_EN = 0;
`endif

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] btn_stbl;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;
    logic [N_CH-1:0] btn_long;

    module_debouncer_multi #(
        .N_CH          (N_CH),
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .LONG_CYCLES   (LONG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .btn_stbl (btn_stbl),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .btn_long (btn_long)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a delay line of SYNC samples, then a run length of
    // consecutive samples disagreeing with the accepted level.
    int              m_dly  [N_CH][SYNC];
    int              m_run  [N_CH];
    int              m_hold [N_CH];
    logic [N_CH-1:0] e_stbl, e_rise, e_fall, e_long;
    logic [N_CH-1:0] prev_rise, prev_fall;

    task automatic check_vec(input string tag, input logic [N_CH-1:0] obs,
                             input logic [N_CH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [N_CH-1:0] b, input logic r);
        for (int ch = 0; ch < N_CH; ch++) begin
            if (!r) begin
                for (int k = 0; k < SYNC; k++) m_dly[ch][k] = 0;
                m_run[ch]  = 0;
                m_hold[ch] = 0;
                e_stbl[ch] = 1'b0;
                e_rise[ch] = 1'b0;
                e_fall[ch] = 1'b0;
                e_long[ch] = 1'b0;
            end else begin
                int  s_now;
                bit  was_hi;
                bit  settled_hi;
                s_now      = m_dly[ch][SYNC-1];
                for (int k = SYNC - 1; k > 0; k--) m_dly[ch][k] = m_dly[ch][k-1];
                m_dly[ch][0] = int'(b[ch]);
                was_hi     = e_stbl[ch];
                settled_hi = e_stbl[ch] && (m_run[ch] == 0);
                e_rise[ch] = 1'b0;
                e_fall[ch] = 1'b0;
                e_long[ch] = 1'b0;
                if (s_now != int'(e_stbl[ch])) begin
                    m_run[ch]++;
                    if (m_run[ch] == STABLE) begin
                        e_stbl[ch] = ~e_stbl[ch];
                        e_rise[ch] = e_stbl[ch];
                        e_fall[ch] = ~e_stbl[ch];
                        m_run[ch]  = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
                // Long press: pulse on the LONG-th settled-high cycle after acceptance.
                if (!was_hi) begin
                    m_hold[ch] = 0;
                end else if (settled_hi && m_hold[ch] < LONG) begin
                    m_hold[ch]++;
                    if (m_hold[ch] == LONG && LP_EN == 1) e_long[ch] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(btn, rst);
        #1;
        check_vec("stbl", btn_stbl, e_stbl);
        check_vec("rise", btn_rise, e_rise);
        check_vec("fall", btn_fall, e_fall);
        check_vec("long", btn_long, e_long);
        check_vec("rise_fall_overlap", btn_rise & btn_fall, '0);
        check_vec("rise_twice", btn_rise & prev_rise, '0);
        check_vec("fall_twice", btn_fall & prev_fall, '0);
        prev_rise = btn_rise;
        prev_fall = btn_fall;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int a_at, b_at, cnt_a, cnt_b, cnt_c;
        int hold_left [N_CH];

        rst       = 1'b0;
        btn       = '0;
        prev_rise = '0;
        prev_fall = '0;
        e_stbl    = '0;
        e_rise    = '0;
        e_fall    = '0;
        e_long    = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            m_run[ch]  = 0;
            m_hold[ch] = 0;
            for (int k = 0; k < SYNC; k++) m_dly[ch][k] = 0;
        end
        #1;

        // 1. Reset held with both buttons pressed, then release.
        btn = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("rst_stbl", btn_stbl, 2'b00);
            check_vec("rst_edges", btn_rise | btn_fall | btn_long, 2'b00);
        end
        rst   = 1'b1;
        a_at  = -1;
        cnt_a = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (btn_stbl[0] && a_at < 0) a_at = k;
            if (btn_rise[0]) cnt_a++;
        end
        check_int("t1_rise_latency", a_at, 5);
        check_int("t1_rise_count", cnt_a, 1);

        // 2. Clean press on channel 0 only.
        btn = 2'b00;
        idle(10);
        btn   = 2'b01;
        a_at  = -1;
        b_at  = -1;
        cnt_a = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (btn_stbl[0] && a_at < 0) a_at = k;
            if (btn_rise[0] && b_at < 0) b_at = k;
            if (btn_rise[0]) cnt_a++;
        end
        check_int("t2_stbl_latency", a_at, 5);
        check_int("t2_rise_cycle", b_at, 5);
        check_int("t2_rise_count", cnt_a, 1);
        check_int("t2_ch1_quiet", int'(btn_stbl[1]), 0);

        // 3. Bounce on channel 0 shorter than the acceptance time.
        btn = 2'b00;
        idle(10);
        cnt_a = 0;
        for (int k = 0; k < 4; k++) begin
            btn[0] = ~k[0];
            for (int j = 0; j < 2; j++) begin
                tick();
                if (btn_stbl[0] || btn_rise[0] || btn_fall[0]) cnt_a++;
            end
        end
        btn[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (btn_stbl[0] || btn_rise[0] || btn_fall[0]) cnt_a++;
        end
        check_int("t3_bounce_activity", cnt_a, 0);

        // 4. Simultaneous release on both channels.
        btn = 2'b11;
        idle(12);
        check_vec("t4_both_high", btn_stbl, 2'b11);
        btn   = 2'b00;
        a_at  = -1;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (btn_fall == 2'b11 && a_at < 0) a_at = k;
            if (btn_fall[0]) cnt_a++;
            if (btn_fall[1]) cnt_b++;
        end
        check_int("t4_fall_cycle", a_at, 5);
        check_int("t4_fall_count0", cnt_a, 1);
        check_int("t4_fall_count1", cnt_b, 1);
        check_vec("t4_both_low", btn_stbl, 2'b00);

        // 5. Reset during a partial count on channel 1.
        btn = 2'b10;
        idle(3);
        check_int("t5_pre_rst", int'(btn_stbl[1]), 0);
        rst = 1'b0;
        tick();
        check_vec("t5_in_rst", btn_stbl | btn_rise, 2'b00);
        rst  = 1'b1;
        a_at = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (btn_stbl[1] && a_at < 0) a_at = k;
        end
        check_int("t5_rise_latency", a_at, 5);

        // 6. Long press on channel 0, then release and press again.
        btn = 2'b00;
        idle(12);
        btn   = 2'b01;
        a_at  = -1;
        b_at  = -1;
        cnt_a = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (btn_rise[0] && a_at < 0) a_at = k;
            if (btn_long[0] && b_at < 0) b_at = k;
            if (btn_long[0]) cnt_a++;
        end
        check_int("t6_long_count", cnt_a, LP_EN);
        check_int("t6_long_cycle", b_at, (LP_EN == 1) ? a_at + LONG : -1);
        btn = 2'b00;
        idle(12);
        btn   = 2'b01;
        cnt_b = 0;
        cnt_c = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (btn_long[0]) cnt_b++;
            if (btn_long[1]) cnt_c++;
        end
        check_int("t6_second_long", cnt_b, LP_EN);
        check_int("t6_ch1_long", cnt_c, 0);

        // 7. Random bouncing on both channels with occasional resets.
        btn = 2'b00;
        for (int ch = 0; ch < N_CH; ch++) hold_left[ch] = 0;
        for (int k = 0; k < 600; k++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (hold_left[ch] == 0) begin
                    btn[ch]       = ~btn[ch];
                    hold_left[ch] = ($urandom_range(0, 3) == 0)
                                    ? int'($urandom_range(12, 24))
                                    : int'($urandom_range(1, 7));
                end
                hold_left[ch]--;
            end
            rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rst = 1'b1;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/module_debouncer_multi.md
Name: module_debouncer_multi

Overview:
- Parametrised N-channel push-button debouncer. Each channel has its own synchroniser, its own stability counter, and its own press/release edge pulses.
- Successor to the single-button debouncer. Sits between the board button/switch pins and the control FSMs, which consume the clean levels and the one-cycle edge pulses.
- Each channel is independent. All channels share one clock.

Parameters:
- N_CH, 4: number of independent button channels (≥1).
- SYNC_STAGES, 2: flip-flops in the input synchroniser chain (≥2).
- STABLE_CYCLES, 50000: consecutive cycles the synchronised input must differ from the current stable level before the level is accepted (≥2).
- CNT_W, $clog2(STABLE_CYCLES+1): stability counter width.
- LONG_CYCLES, 1000000: hold time for the long-press pulse. Used only with DEBOUNCER_LONGPRESS_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low. Sampled on rising clk.
- btn  in  N_CH  raw asynchronous button inputs.
- btn_stbl  out  N_CH  debounced level per channel.
- btn_rise  out  N_CH  one-cycle pulse when btn_stbl goes 0→1.
- btn_fall  out  N_CH  one-cycle pulse when btn_stbl goes 1→0.
- btn_long  out  N_CH  one-cycle long-press pulse. Tied to 0 without DEBOUNCER_LONGPRESS_EN.

Behaviour:
- Reset: clk is the only clock. rst is synchronous and active-low. On any rising clk with rst=0, all of the following clear to 0: synchroniser flops, counters, state, btn_stbl, btn_rise, btn_fall, btn_long. Reset asserted mid-count discards the partial count. After release, a channel whose btn is held at 1 needs the full latency again.
- Synchroniser: btn[i] passes through SYNC_STAGES flops, giving s[i].
- Per-channel FSM has four states:
  - S_LO: btn_stbl=0. If s=1, counter←1 and go to S_WAIT_HI.
  - S_WAIT_HI: if s=0, counter←0 and return to S_LO (glitch rejected, no pulse). Else if counter==STABLE_CYCLES-1, go to S_HI, set btn_stbl←1, pulse btn_rise for one cycle, counter←0. Otherwise counter++.
  - S_HI / S_WAIT_LO: mirror images of the above, with btn_fall pulsed on acceptance.
- Latency: a clean edge on btn settles before the rising clk at cycle 0. btn_stbl changes at the rising edge of cycle SYNC_STAGES+STABLE_CYCLES-1. btn_rise/btn_fall are high during the same cycle btn_stbl first shows the new value.
- Rejection: any pulse or bounce on btn shorter than STABLE_CYCLES cycles (after synchronisation) produces no change and no edge pulse.
- Edge pulses: btn_rise and btn_fall are never high at the same time on one channel, and never high for two consecutive cycles.
- Counter: never exceeds STABLE_CYCLES-1 and does not wrap. It is held at 0 in S_LO and S_HI.
- Channels: all channels are fully independent. Simultaneous events on different channels are each handled in the same cycle.
- Outputs: all outputs are registered. There are no combinational paths from btn.

Optional Feature:
- Macro: DEBOUNCER_LONGPRESS_EN.
- With the macro defined:
  - Each channel adds a hold counter (width $clog2(LONG_CYCLES+1)), cleared on reset and whenever btn_stbl=0.
  - While in S_HI (including S_WAIT_HI→S_HI entry cycle excluded), the counter increments.
  - When it reaches LONG_CYCLES-1, btn_long pulses for one cycle and the counter saturates.
  - Only one pulse per press. A new press (a fresh btn_rise) re-arms it.
- Without the macro: btn_long is constant 0, and no hold counter logic exists.

Decomposition:
- Package debouncer_pkg contains:
  - typedef enum logic [1:0] {S_LO, S_WAIT_HI, S_HI, S_WAIT_LO} deb_state_t.
  - Default constants DEB_SYNC_STAGES=2 and DEB_STABLE_CYCLES=50000.
- Sub-module debounce_channel holds one channel: synchroniser, FSM, counter and optional long-press logic.
- module_debouncer_multi is a generate-for array of N_CH debounce_channel instances.

Test Plan:
- All benches use N_CH=2, SYNC_STAGES=2, STABLE_CYCLES=4, LONG_CYCLES=10 and a 20 ns clock.
1. Reset: hold rst=0 for 3 cycles with btn=2'b11. All outputs are 0 throughout. After rst=1, btn_stbl[0] rises exactly 5 cycles later with a single btn_rise[0] pulse.
2. Clean press: btn[0] 0→1 held. btn_stbl[0]=1 at cycle 5, btn_rise[0] high for exactly cycle 5. Channel 1 outputs stay 0.
3. Bounce rejection: btn[0] toggles 1,0,1,0 with 2-cycle widths, then settles at 0. btn_stbl[0], btn_rise[0] and btn_fall[0] remain 0 throughout.
4. Release and simultaneity: both channels stable at 1, then btn=2'b00 on the same edge. btn_fall=2'b11 in the same single cycle, and btn_stbl=2'b00.
5. Mid-count reset: btn[1]=1 for 3 cycles, then rst=0 for 1 cycle, then rst=1. btn_stbl[1] does not rise until 5 further cycles have elapsed.
6. With DEBOUNCER_LONGPRESS_EN: hold btn[0]=1. btn_long[0] pulses once, 10 cycles after btn_rise[0], and does not repeat. Release and re-press produces a second pulse. Without the macro, btn_long stays 2'b00.
